// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a dual 4-to-1 selector through 0..3 and packs both channels into data_out.
// Define AUTO_RESCAN_EN to restart scanning straight from DONE instead of returning to IDLE.
module mux_scan_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y1,
    input  logic       y2,
    output logic       s0,
    output logic       s1,
    output logic       e1,
    output logic       e2,
    output logic       busy,
    output logic       done,
    output logic [7:0] data_out
);
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [1:0] idx, idx_n;
    logic [7:0] shadow, shadow_n;
    logic       scan_n;

    assign scan_n = state_n == SETTLE || state_n == SAMPLE;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        shadow_n = shadow;
        case (state)
            IDLE: if (start) begin
                state_n = SETTLE;
                cnt_n   = 4'd0;
                idx_n   = 2'd0;
            end
            SETTLE: begin
                cnt_n   = cnt + 4'd1;
                state_n = cnt == 4'(SETTLE_CYCLES - 1) ? SAMPLE : SETTLE;
            end
            SAMPLE: begin
                shadow_n[{1'b0, idx}] = y1;
                shadow_n[{1'b1, idx}] = y2;
                cnt_n   = 4'd0;
                idx_n   = idx + 2'd1;
                state_n = idx == 2'd3 ? DONE : SETTLE;
            end
`ifdef AUTO_RESCAN_EN
            DONE: begin
                state_n = SETTLE;
                cnt_n   = 4'd0;
                idx_n   = 2'd0;
            end
`else
            DONE: state_n = IDLE;
`endif
            default: state_n = IDLE;
        endcase
    end

    // outputs are registered from the next-state decode so they track state without extra latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            idx      <= 2'd0;
            shadow   <= 8'h00;
            data_out <= 8'h00;
            {s1, s0} <= 2'b00;
            e1       <= 1'b1;
            e2       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            shadow   <= shadow_n;
            if (state_n == DONE) data_out <= shadow_n;
            {s1, s0} <= scan_n ? idx_n : 2'b00;
            e1       <= !scan_n;
            e2       <= !scan_n;
            busy     <= state_n != IDLE;
            done     <= state_n == DONE;
        end
    end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed checks of mux_scan_ctrl against a behavioural 74hc153 model.
module tb_mux_scan_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, g = 1'b0;
    logic [3:0] a_pat = 4'h0, b_pat = 4'h0;
    logic       y1, y2, s0, s1, e1, e2, busy, done;
    logic [7:0] data_out;
    logic [1:0] exp_sel;
    int         passed = 0, total = 0, ndone, busy_ok;

    always #5 clk = ~clk;

    // selector model: disabled channels drive low, g injects an early-settle glitch
    assign y1 = (e1 ? 1'b0 : a_pat[{s1, s0}]) ^ g;
    assign y2 = (e2 ? 1'b0 : b_pat[{s1, s0}]) ^ g;

    mux_scan_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .y1(y1), .y2(y2),
        .s0(s0), .s1(s1), .e1(e1), .e2(e2), .busy(busy), .done(done), .data_out(data_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        cyc();
        chk("reset_outs", {s1, s0, e1, e2, busy, done}, 6'b001100);
        chk("reset_data", data_out, 8'h00);
        rst_n = 1'b1;
        cyc(); cyc();
        chk("idle_outs", {s1, s0, e1, e2, busy, done}, 6'b001100);

        a_pat = 4'b1010; b_pat = 4'b0110; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k <= 13; k++) begin
            if (k > 0) cyc();
            exp_sel = k < 12 ? 2'(k / 3) : 2'd0;
            chk($sformatf("t2_outs_k%0d", k), {s1, s0, e1, e2, busy, done},
                {exp_sel, k < 12 ? 2'b00 : 2'b11, k <= 12, k == 12});
            if (k == 11) chk("t2_data_hold", data_out, 8'h00);
            if (k == 12) chk("t2_data", data_out, 8'h6A);
        end
        chk("t2_data_after", data_out, 8'h6A);

        a_pat = 4'b0101; b_pat = 4'b1001; start = 1'b1;
        cyc();
        start = 1'b0;
        ndone = 0; busy_ok = 1;
        for (int k = 0; k < 30; k++) begin
            if (k > 0) cyc();
            ndone += int'(done);
            if (k <= 12 && !busy) busy_ok = 0;
            start = k == 2 || k == 6;
        end
        start = 1'b0;
        chk("t3_done_count", ndone, 1);
        chk("t3_busy_cont", busy_ok, 1);
        chk("t3_data", data_out, 8'h95);

        a_pat = 4'b1100; b_pat = 4'b0011; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k <= 13; k++) begin
            if (k > 0) cyc();
            g = k % 3 == 0 && k < 12;
        end
        g = 1'b0;
        chk("t4_data", data_out, 8'h3C);

        a_pat = 4'b0001; b_pat = 4'b1000; start = 1'b1;
        cyc();
        ndone = 0;
        for (int k = 0; k <= 41; k++) begin
            if (k > 0) cyc();
            ndone += int'(done);
            if (k == 12) begin
                chk("t5_done1", done, 1'b1);
                chk("t5_data1", data_out, 8'h81);
                a_pat = 4'b1111; b_pat = 4'b0000;
            end
            if (k == 13) chk("t5_idle1", busy, 1'b0);
            if (k == 14) chk("t5_busy2", busy, 1'b1);
            if (k == 20) chk("t5_hold", data_out, 8'h81);
            if (k == 26) begin
                chk("t5_done2", done, 1'b1);
                chk("t5_data2", data_out, 8'h0F);
                a_pat = 4'b0110; b_pat = 4'b1011;
            end
            if (k == 27) chk("t5_idle2", busy, 1'b0);
            if (k == 40) begin
                chk("t5_done3", done, 1'b1);
                chk("t5_data3", data_out, 8'hB6);
                start = 1'b0;
            end
        end
        chk("t5_done_count", ndone, 3);

        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        chk("t1_mid_settle", {e1, e2, busy}, 3'b001);
        #1 rst_n = 1'b0;
        #1;
        chk("t1_async_outs", {s1, s0, e1, e2, busy, done}, 6'b001100);
        chk("t1_async_data", data_out, 8'h00);
        cyc();
        rst_n = 1'b1;
        cyc(); cyc();
        chk("t1_post_outs", {s1, s0, e1, e2, busy, done}, 6'b001100);
        chk("t1_post_data", data_out, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
